// File: rtl/reg_file_8x16_pkg.sv
// Shared types and constants for the 8x16 architectural register file.
package reg_file_8x16_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int R0_IDX   = 0;
    localparam int CNT_W    = 8;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam logic [CNT_W-1:0] WR_COUNT_MAX = '1;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t a);
        addr_onehot    = '0;
        addr_onehot[a] = 1'b1;
    endfunction
endpackage

// File: rtl/reg_file_8x16_if.sv
// Read/write bus of the register file; decode drives it as master.
interface reg_file_8x16_if;
    import reg_file_8x16_pkg::*;

    reg_addr_t          rd_addr_a;
    reg_data_t          rd_data_a;
    reg_addr_t          rd_addr_b;
    reg_data_t          rd_data_b;
    logic               wr_en;
    reg_addr_t          wr_addr;
    reg_data_t          wr_data;
    logic [CNT_W-1:0]   wr_count;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
        input  rd_data_a, rd_data_b, wr_count
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
        output rd_data_a, rd_data_b, wr_count
    );
endinterface

// File: rtl/reg_file_8x16_reg_cell16.sv
// Single 16-bit storage cell with async active-low clear and write enable.
module reg_cell16
    import reg_file_8x16_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      we_i,
    input  reg_data_t d_i,
    output reg_data_t q_o
);
    reg_data_t data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (we_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/reg_file_8x16.sv
// 8x16 register file: two combinational read ports, one write port,
// optional hardwired-zero R0 and optional same-cycle write bypass.
module reg_file_8x16
    import reg_file_8x16_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1,
    parameter bit BYPASS  = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_file_8x16_if.slave bus
);
    logic [NUM_REGS-1:0] wr_sel;
    logic                wr_commit;
    reg_data_t           regs [NUM_REGS];
    logic [CNT_W-1:0]    wr_count_q;
    logic [CNT_W-1:0]    wr_count_d;
    reg_data_t           rd_data_a;
    reg_data_t           rd_data_b;

    always_comb begin
        wr_sel = bus.wr_en ? addr_onehot(bus.wr_addr) : '0;
        if (R0_ZERO) begin
            wr_sel[R0_IDX] = 1'b0;
        end
    end

    assign wr_commit = |wr_sel;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        if (R0_ZERO && (i == R0_IDX)) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_reg
            reg_cell16 u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .we_i  (wr_sel[i]),
                .d_i   (bus.wr_data),
                .q_o   (regs[i])
            );
        end
    end

    // Bypass is suppressed while in reset so reads stay at zero.
    always_comb begin
        rd_data_a = regs[bus.rd_addr_a];
        if (BYPASS && rst_n && bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
            rd_data_a = bus.wr_data;
        end
        if (R0_ZERO && (bus.rd_addr_a == reg_addr_t'(R0_IDX))) begin
            rd_data_a = '0;
        end
    end

    always_comb begin
        rd_data_b = regs[bus.rd_addr_b];
        if (BYPASS && rst_n && bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
            rd_data_b = bus.wr_data;
        end
        if (R0_ZERO && (bus.rd_addr_b == reg_addr_t'(R0_IDX))) begin
            rd_data_b = '0;
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit && (wr_count_q != WR_COUNT_MAX)) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.rd_data_a = rd_data_a;
    assign bus.rd_data_b = rd_data_b;
    assign bus.wr_count  = wr_count_q;
endmodule

// File: tb/tb_reg_file_8x16.sv
// Bench for reg_file_8x16: two configurations driven in parallel and
// compared every cycle against an array-based model.
module tb_reg_file_8x16;
    import reg_file_8x16_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        t_we = 1'b0;
    logic [2:0]  t_wa = '0;
    logic [15:0] t_wd = '0;
    logic [2:0]  t_ra = '0;
    logic [2:0]  t_rb = '0;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [2][8];
    int          cnt [2];
    bit          r0z [2] = '{1'b1, 1'b0};
    bit          byp [2] = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    reg_file_8x16_if if0 ();
    reg_file_8x16_if if1 ();

    assign if0.rd_addr_a = t_ra;  assign if1.rd_addr_a = t_ra;
    assign if0.rd_addr_b = t_rb;  assign if1.rd_addr_b = t_rb;
    assign if0.wr_en     = t_we;  assign if1.wr_en     = t_we;
    assign if0.wr_addr   = t_wa;  assign if1.wr_addr   = t_wa;
    assign if0.wr_data   = t_wd;  assign if1.wr_data   = t_wd;

    reg_file_8x16 #(.R0_ZERO(1'b1), .BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    reg_file_8x16 #(.R0_ZERO(1'b0), .BYPASS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input int c, input logic [2:0] a);
        if (r0z[c] && a == 3'd0) return 16'h0000;
        if (!rst_n) return 16'h0000;
        if (byp[c] && t_we && t_wa == a) return t_wd;
        return mem[c][a];
    endfunction

    initial begin
        for (int c = 0; c < 2; c++) begin
            cnt[c] = 0;
            for (int r = 0; r < 8; r++) mem[c][r] = 16'h0000;
        end
    end

    always @(negedge rst_n) begin
        for (int c = 0; c < 2; c++) begin
            cnt[c] = 0;
            for (int r = 0; r < 8; r++) mem[c][r] = 16'h0000;
        end
    end

    always @(posedge clk) begin
        if (rst_n && t_we) begin
            for (int c = 0; c < 2; c++) begin
                if (!(r0z[c] && t_wa == 3'd0)) begin
                    mem[c][t_wa] = t_wd;
                    if (cnt[c] < 255) cnt[c]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("c0_rd_a",  if0.rd_data_a, exp_rd(0, t_ra));
        chk("c0_rd_b",  if0.rd_data_b, exp_rd(0, t_rb));
        chk("c0_count", {8'h00, if0.wr_count}, 16'(cnt[0]));
        chk("c1_rd_a",  if1.rd_data_a, exp_rd(1, t_ra));
        chk("c1_rd_b",  if1.rd_data_b, exp_rd(1, t_rb));
        chk("c1_count", {8'h00, if1.wr_count}, 16'(cnt[1]));
    end

    task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb);
        @(posedge clk);
        #1;
        t_we = we; t_wa = wa; t_wd = wd; t_ra = ra; t_rb = rb;
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        // Reads during reset, then a clean sweep after release
        step(1'b0, 3'd0, 16'h0, 3'd5, 3'd6);
        chk("rst_rd_a_lit", if1.rd_data_a, 16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i));
            chk("sweep_c1_a_lit", if1.rd_data_a, 16'h0000);
        end
        chk("rst_count_lit", {8'h00, if1.wr_count}, 16'h0000);

        step(1'b1, 3'd1, 16'hA5A5, 3'd0, 3'd0);
        step(1'b1, 3'd7, 16'h5A5A, 3'd0, 3'd0);
        step(1'b1, 3'd3, 16'hFFFF, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 3'd7, 3'd1);
        chk("wr_r7_lit", if0.rd_data_a, 16'h5A5A);
        chk("wr_r1_lit", if0.rd_data_b, 16'hA5A5);
        chk("wr_cnt3_lit", {8'h00, if0.wr_count}, 16'd3);
        step(1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);
        chk("wr_r3_lit", if0.rd_data_a, 16'hFFFF);
        chk("same_addr_lit", if0.rd_data_b, 16'hFFFF);

        step(1'b1, 3'd0, 16'h1234, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        chk("r0_zero_lit", if0.rd_data_a, 16'h0000);
        chk("r0_zero_cnt_lit", {8'h00, if0.wr_count}, 16'd3);
        chk("r0_plain_lit", if1.rd_data_a, 16'h1234);
        chk("r0_plain_cnt_lit", {8'h00, if1.wr_count}, 16'd4);

        step(1'b1, 3'd2, 16'h0001, 3'd0, 3'd0);
        step(1'b1, 3'd2, 16'h00F0, 3'd2, 3'd2);
        chk("haz_nobyp_lit", if0.rd_data_a, 16'h0001);
        chk("haz_byp_lit", if1.rd_data_b, 16'h00F0);
        step(1'b0, 3'd0, 16'h0000, 3'd2, 3'd2);
        chk("haz_after_lit", if0.rd_data_a, 16'h00F0);

        step(1'b1, 3'd4, 16'hBEEF, 3'd4, 3'd4);
        step(1'b0, 3'd0, 16'h0000, 3'd4, 3'd4);
        chk("pre_rst_lit", if0.rd_data_a, 16'hBEEF);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd_lit", if0.rd_data_a, 16'h0000);
        chk("async_rst_c1_lit", if1.rd_data_b, 16'h0000);
        chk("async_rst_cnt_lit", {8'h00, if0.wr_count}, 16'h0000);
        @(negedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        for (int i = 0; i < 300; i++) begin
            step(1'b1, 3'd5, 16'(i), 3'd5, 3'd0);
        end
        step(1'b0, 3'd5, 16'h0000, 3'd5, 3'd5);
        chk("sat_cnt_c0_lit", {8'h00, if0.wr_count}, 16'h00FF);
        chk("sat_cnt_c1_lit", {8'h00, if1.wr_count}, 16'h00FF);
        chk("wr_dis_keep_lit", if0.rd_data_a, 16'd299);
        step(1'b0, 3'd5, 16'h0000, 3'd5, 3'd5);
        chk("wr_dis_keep2_lit", if1.rd_data_b, 16'd299);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
